// File: rtl/mem_dump_reader.sv
// Walks [start_addr, end_addr) through a synchronous-read RAM port and streams (addr, data) beats on valid/ready.
// Optional checksum beat enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   end_addr,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_range,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [REG_WIDTH-1:0]  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [REG_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_OUT,
    S_DONE
`ifdef MEM_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  // One bit wider than the RAM address so a range ending at MEM_DEPTH never wraps.
  logic [ADDR_WIDTH:0]   cur_addr;
  logic [ADDR_WIDTH:0]   end_q;
  logic [ADDR_WIDTH:0]   addr_next;
  logic                  range_ok;
  logic                  start_ok;
  logic                  handshake;
  logic                  is_final;

  assign addr_next = cur_addr + ONE;
  assign is_final  = (addr_next == end_q);
  assign range_ok  = ({1'b0, start_addr} < end_addr) && (end_addr <= DEPTH_W);
  assign start_ok  = (state_q == S_IDLE) && start && range_ok;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_rd_en = (state_q == S_READ);
    mem_addr  = cur_addr[ADDR_WIDTH-1:0];
    out_valid = (state_q == S_OUT);
`ifdef MEM_DUMP_CHECKSUM_EN
    if (state_q == S_CSUM) out_valid = 1'b1;
`endif
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_READ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_OUT;
      S_OUT: begin
        if (handshake) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          state_d = is_final ? S_CSUM : S_READ;
`else
          state_d = out_last ? S_DONE : S_READ;
`endif
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM:  if (handshake) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats any handshake; IDLE ignores it so a coincident start still wins.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [REG_WIDTH-1:0] sum_q;
`endif

  // NOTE: only flops are reset here; the RAM itself is external and never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      end_q     <= '0;
      err_range <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      err_range <= (state_q == S_IDLE) && start && !range_ok;
      if (start_ok) begin
        cur_addr <= {1'b0, start_addr};
        end_q    <= end_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end else if (!abort) begin
        case (state_q)
          S_LATCH: begin
            out_data <= mem_rd_data;
            out_addr <= cur_addr[ADDR_WIDTH-1:0];
`ifdef MEM_DUMP_CHECKSUM_EN
            out_last <= 1'b0;
`else
            out_last <= is_final;
`endif
          end
          S_OUT: begin
            if (handshake) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              sum_q <= sum_q + out_data;
              if (is_final) begin
                out_addr <= end_q[ADDR_WIDTH-1:0];
                out_data <= sum_q + out_data;
                out_last <= 1'b1;
              end else begin
                cur_addr <= addr_next;
              end
`else
              if (!out_last) cur_addr <= addr_next;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: table of dump ranges plus abort and mid-dump reset sequences.
// Follows MEM_DUMP_CHECKSUM_EN to expect the extra checksum beat.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_addr;
  logic [16:0] end_addr;
  logic        abort;
  logic        busy, done, err_range, mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_addr;
  logic [7:0]  out_data;

  logic [7:0]  ram [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [15:0] sa;
    logic [16:0] ea;
    int          period;
    bit          err;
  } vec_t;

  mem_dump_reader #(.REG_WIDTH(8), .ADDR_WIDTH(16), .MEM_DEPTH(65536)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .abort(abort), .busy(busy), .done(done), .err_range(err_range), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_err"},       err_range, 0);
    check({tag, "_rd_en"},     mem_rd_en, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_addr"},  out_addr, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_last"},  out_last, 0);
  endtask

  // Runs one dump from a negedge; returns at the negedge after done (or after the error window).
  task automatic run_dump(input logic [15:0] sa, input logic [16:0] ea, input int period,
                          input bit exp_err, input bit abort_with_start);
    int          n_exp, beat, last_hs, n_rd;
    bit          seen_done, seen_err, seen_busy, prev_stall;
    logic [15:0] pa, ex_a;
    logic [7:0]  pd, ex_d, sum;
    logic        pl, ex_l;
    n_exp = exp_err ? 0 : int'(ea) - int'(sa);
    start = 1'b1; start_addr = sa; end_addr = ea; abort = abort_with_start; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    beat = 0; sum = 8'h00; last_hs = -10; n_rd = 0;
    seen_done = 0; seen_err = 0; seen_busy = 0; prev_stall = 0;
    pa = '0; pd = '0; pl = 1'b0;
    for (int cyc = 1; cyc < 2000 && !seen_done && !(exp_err && cyc > 5); cyc++) begin
      if (mem_rd_en) n_rd++;
      if (busy) seen_busy = 1;
      if (err_range) begin
        check("err_range_cycle", cyc, 1);
        seen_err = 1;
      end
      if (done) begin
        check("done_after_last_hs", cyc - last_hs, 1);
        seen_done = 1;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_addr",  out_addr, pa);
        check("stall_data",  out_data, pd);
        check("stall_last",  out_last, pl);
      end
      out_ready = ((cyc % period) == 0);
      if (out_valid && out_ready) begin
        if (beat < n_exp) begin
          ex_a = sa + 16'(beat);
          ex_d = ram[ex_a];
          ex_l = CHK ? 1'b0 : (beat == n_exp - 1);
          sum  = sum + ex_d;
        end else begin
          ex_a = ea[15:0];
          ex_d = sum;
          ex_l = 1'b1;
        end
        check("beat_addr", out_addr, ex_a);
        check("beat_data", out_data, ex_d);
        check("beat_last", out_last, ex_l);
        if (period == 1 && beat > 0 && beat < n_exp) check("beat_spacing", cyc - last_hs, 3);
        last_hs = cyc;
        beat++;
        prev_stall = 0;
      end else if (out_valid) begin
        prev_stall = 1; pa = out_addr; pd = out_data; pl = out_last;
      end else begin
        prev_stall = 0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("beat_count", beat, n_exp + ((CHK && !exp_err) ? 1 : 0));
    check("err_seen",   seen_err, exp_err);
    check("done_seen",  seen_done, !exp_err);
    check("busy_seen",  seen_busy, !exp_err);
    check("read_count", n_rd, n_exp);
    check("idle_busy",  busy, 0);
    check("idle_done",  done, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int   hs;
    bit   seen_done;
    bit   got_valid;

    vecs[0] = '{sa: 16'h0010, ea: 17'h00014, period: 1, err: 1'b0};
    vecs[1] = '{sa: 16'h0010, ea: 17'h00014, period: 4, err: 1'b0};
    vecs[2] = '{sa: 16'h0020, ea: 17'h00020, period: 1, err: 1'b1};
    vecs[3] = '{sa: 16'h0000, ea: 17'h10001, period: 1, err: 1'b1};
    vecs[4] = '{sa: 16'h0030, ea: 17'h00020, period: 1, err: 1'b1};
    vecs[5] = '{sa: 16'hFFFF, ea: 17'h10000, period: 1, err: 1'b0};

    for (int i = 0; i < 65536; i++) ram[i] = 8'((i * 7 + 3) & 255);
    ram[16'h0010] = 8'hA5; ram[16'h0011] = 8'h5A; ram[16'h0012] = 8'hFF; ram[16'h0013] = 8'h00;
    ram[16'hFFFF] = 8'h3C; ram[16'h0040] = 8'h99;

    reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_dump(vecs[i].sa, vecs[i].ea, vecs[i].period, vecs[i].err, 1'b0);

    // Abort while the sixth beat is offered and not yet accepted.
    hs = 0; got_valid = 0;
    start = 1'b1; start_addr = 16'h0000; end_addr = 17'h00100;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !got_valid; cyc++) begin
      if (out_valid && hs == 5) begin
        out_ready = 1'b0; abort = 1'b1; got_valid = 1;
      end else begin
        if (out_valid) hs++;
        @(negedge clk);
      end
    end
    check("abort_reached", hs, 5);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid_drop", out_valid, 0);
    check("abort_busy",       busy, 0);
    seen_done = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (done || mem_rd_en || busy) seen_done = 1;
      @(negedge clk);
    end
    check("abort_quiet", seen_done, 0);

    // Abort coincident with start in IDLE must be ignored.
    run_dump(16'h0040, 17'h00041, 1, 1'b0, 1'b1);

    // Reset asserted while a beat is pending.
    start = 1'b1; start_addr = 16'h0010; end_addr = 17'h00014; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; got_valid = 0;
    for (int cyc = 0; cyc < 20 && !got_valid; cyc++) begin
      if (out_valid) got_valid = 1;
      else @(negedge clk);
    end
    check("rst_mid_valid", got_valid, 1);
    check("rst_mid_data_pre", out_data, 8'hA5);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_after_busy", busy, 0);
    check("rst_mid_after_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
Read-side counterpart to the memory override path. It walks a contiguous address range of the system RAM through the RAM's synchronous read port and streams each byte out as a (address, data) beat on a valid/ready interface. Testbench monitors and debug capture logic use it to take memory snapshots without hierarchical peeking. It sits between the RAM read port and any stream consumer.

Parameters:
REG_WIDTH, 8, data width of one memory word and of out_data
ADDR_WIDTH, 16, width of all address ports
MEM_DEPTH, 65536, number of valid words; legal addresses are 0..MEM_DEPTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a dump; sampled only in IDLE
start_addr  input  ADDR_WIDTH  first address, inclusive; sampled with start
end_addr  input  ADDR_WIDTH+1  last address, exclusive; sampled with start
abort  input  1  synchronous cancel of a running dump
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a dump completes normally
err_range  output  1  one-cycle pulse when start is rejected
mem_rd_en  output  1  RAM read strobe
mem_addr  output  ADDR_WIDTH  RAM read address
mem_rd_data  input  REG_WIDTH  RAM read data, valid the cycle after mem_rd_en
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the beat
out_addr  output  ADDR_WIDTH  address of the current beat
out_data  output  REG_WIDTH  data of the current beat
out_last  output  1  marks the final beat of the dump

Behaviour:
- Reset, asynchronous: state goes to IDLE. All outputs go to 0, including the address counter and the latched end address.
- FSM states: IDLE, READ, LATCH, OUT, DONE.
- IDLE, start=1, range legal (start_addr < end_addr and end_addr <= MEM_DEPTH): latch both bounds, set cur_addr = start_addr, go to READ.
- IDLE, start=1, range illegal: pulse err_range for 1 cycle, stay in IDLE, perform no memory access.
- READ: mem_rd_en=1 and mem_addr=cur_addr for exactly 1 cycle, then go to LATCH. mem_rd_en is 0 in every other state.
- LATCH: register mem_rd_data into out_data and cur_addr into out_addr. Set out_last = (cur_addr+1 == end_addr). Go to OUT.
- OUT: out_valid=1. out_addr, out_data and out_last are held stable until out_valid && out_ready.
  - On handshake, if out_last: go to DONE. Otherwise increment cur_addr and go to READ.
  - Minimum cost is 3 cycles per byte, plus any ready stall.
- DONE: done=1 for 1 cycle, then IDLE. busy is still high in DONE.
- start while busy is ignored and has no side effects.
- abort=1 in any non-IDLE state: next state is IDLE and out_valid drops the same edge. This is the only case where out_valid may drop without a handshake. No done pulse is produced, and any in-flight read data is discarded.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- Single-word range (end_addr = start_addr+1): exactly one beat, with out_last=1.
- Range ending at MEM_DEPTH: no wrap. The address counter is ADDR_WIDTH+1 bits internally.
- Reset asserted mid-dump: everything clears immediately. No done or err_range pulse.

Optional Feature:
MEM_DUMP_CHECKSUM_EN
- Defined:
  - An 8-bit running sum, mod 2^REG_WIDTH, accumulates each data beat at its handshake. It is cleared on accepted start.
  - After the final data beat, the FSM enters a CSUM state and emits one extra beat: out_addr = end_addr[ADDR_WIDTH-1:0], out_data = the sum, out_last=1.
  - out_last is 0 on every data beat.
  - DONE follows the checksum handshake.
- Undefined: no CSUM state and no sum register; out_last is on the final data beat.

Test Plan:
- Preload RAM[0x10..0x13] = A5,5A,FF,00. start with 0x10/0x14, out_ready=1 -> 4 beats (10:A5, 11:5A, 12:FF, 13:00), out_last only on 0x13, done 1 cycle after the last handshake, 3-cycle beat spacing.
- Same range with out_ready toggling 1-of-4 cycles -> out_addr/out_data/out_valid stable during stalls, identical beat sequence.
- start 0x20/0x20, then start 0x00/MEM_DEPTH+1 -> err_range pulse each time, mem_rd_en never asserted, busy stays 0.
- Single word start 0xFFFF/0x10000, RAM[0xFFFF]=3C -> one beat FFFF:3C with out_last=1, no address wrap, done pulses.
- start 0x00/0x100, abort after the 5th handshake -> out_valid drops next cycle, busy=0, no done; a new start 0x40/0x41 then completes normally.
- With MEM_DUMP_CHECKSUM_EN, range 0x10..0x13 as above -> 5th beat 14:FE (A5+5A+FF+00 mod 256) with out_last=1. Also assert reset mid-dump -> all outputs 0 immediately.
